urisc_dmem_arbiter: RTL

//  Shares the single-port, async-read data memory between the URISC core (owner) and a host

---
 rtl/urisc_pkg.sv | 15 +
 rtl/urisc_sat_counter.sv | 40 ++++
 rtl/urisc_dmem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/urisc_pkg.sv
// Shared types and helpers for the URISC data-memory arbiter.
package urisc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Address width for a given memory depth; a one-word memory still needs one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/urisc_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered saturation flag.
module urisc_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != WIDTH'(MAX))) begin
      count_d = count_q + WIDTH'(1);
    end
    sat_d = (count_d == WIDTH'(MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/urisc_dmem_arbiter.sv
// Shares the URISC data RAM between the core (zero-latency owner) and a queued
// host debug/loader port that uses cycles the core leaves idle.
module urisc_dmem_arbiter
  import urisc_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned MAX_WAIT = 15,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_cs,
  input  logic             core_read,
  input  logic             core_write,
  input  logic [AW-1:0]    core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_busy,
  output logic             host_ack,
  output logic [WIDTH-1:0] host_rdata,
  output logic             starve,
  input  logic             starve_clr,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  arb_state_t       state_q, state_d;
  logic             req_we_q, req_we_d;
  logic [AW-1:0]    req_addr_q, req_addr_d;
  logic [WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] rdata_q;
  logic             starve_q, starve_d;
  logic             starve_set;
  logic             cnt_clr, cnt_inc;
  logic [CW-1:0]    wait_cnt;
  logic             wait_sat;
  logic             host_go_c;
  logic             core_read_unused;

  // The RAM reads asynchronously, so the core read strobe adds nothing here.
  assign core_read_unused = core_read;

  assign host_go_c = (state_q == PEND) && !core_cs;

  urisc_sat_counter #(
    .WIDTH (CW),
    .MAX   (MAX_WAIT)
  ) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (wait_cnt),
    .sat_o   (wait_sat)
  );

  // Host request FSM: next state, capture and starvation tracking.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    starve_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_req) begin
          req_we_d    = host_we;
          req_addr_d  = host_addr;
          req_wdata_d = host_wdata;
          cnt_clr     = 1'b1;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (!core_cs) begin
          state_d = ACK;
        end else begin
          cnt_inc    = 1'b1;
          starve_set = wait_sat || (wait_cnt == CW'(MAX_WAIT - 1));
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d == PEND);
    ack_d    = (state_d == ACK);
    starve_d = starve_set ? 1'b1 : (starve_clr ? 1'b0 : starve_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      starve_q    <= starve_d;
      if (host_go_c && !req_we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Memory port mux: core always wins; reset blocks any select or write.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_cs) begin
      mem_cs    = 1'b1;
      mem_we    = core_write;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_go_c) begin
      mem_cs    = 1'b1;
      mem_we    = req_we_q;
      mem_addr  = req_addr_q;
      mem_wdata = req_wdata_q;
    end
    if (reset) begin
      mem_cs = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign core_rdata = core_cs ? mem_rdata : '0;
  assign host_busy  = busy_q;
  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign starve     = starve_q;

endmodule
